// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard: register file geometry,
// counter width and the standard result latencies of the execution units.
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_SRC    = 2;
  localparam int MAX_LAT    = 7;
  localparam int WB_DIST    = 2;
  localparam int CNT_W      = 3;
  localparam int STALL_W    = 32;

  localparam int LAT_ALU    = 0;
  localparam int LAT_LOAD   = 1;
  localparam int LAT_MUL    = 4;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage instruction bundle in, stall/issue decision out. Master is the ID stage,
// slave is the scoreboard; purely combinational signals, no handshake of its own.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic                          forward_en;
  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0]            id_src_check;
  logic [REG_ADDR_W-1:0]         id_dest;
  logic                          id_wb_en;
  logic [CNT_W-1:0]              id_lat;
  logic                          pipe_freeze;
  logic                          id_flush;
  logic                          hazard_detected;
  logic                          issue;
  logic [STALL_W-1:0]            stall_cycles;

  modport master (
    output forward_en, id_valid, id_src, id_src_check, id_dest, id_wb_en, id_lat,
           pipe_freeze, id_flush,
    input  hazard_detected, issue, stall_cycles
  );

  modport slave (
    input  forward_en, id_valid, id_src, id_src_check, id_dest, id_wb_en, id_lat,
           pipe_freeze, id_flush,
    output hazard_detected, issue, stall_cycles
  );

endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: cycles until its register's value is available; 1-cycle load,
// counts down each advancing cycle, holds completely while the pipeline is frozen.
module hazard_sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_freeze,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // A new writer replaces whatever an older writer left behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_freeze) begin
      if (i_load) begin
        r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard driving the IF/ID stall; decision is combinational
// from registered counters, pipe_freeze blocks issue and holds every counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave io_sb
);

  localparam int NREG = 2**REG_ADDR_W;

  logic [CNT_W-1:0]   w_cnt [NREG];
  logic [NUM_SRC-1:0] w_src_hit;
  logic               w_hazard;
  logic               w_issue;
  logic [31:0]        w_lat_ext;
  logic [CNT_W-1:0]   w_lat_clamped;
  logic [CNT_W-1:0]   w_load_val;
  logic [STALL_W-1:0] r_stall;

  // r0 is hard-wired, so it can never be pending.
  assign w_cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    logic w_load;
    assign w_load = w_issue && io_sb.id_wb_en && (io_sb.id_dest == REG_ADDR_W'(r));

    hazard_sb_entry u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_freeze   (io_sb.pipe_freeze),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_cnt      (w_cnt[r])
    );
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_ADDR_W-1:0] w_idx;
    assign w_idx        = io_sb.id_src[k*REG_ADDR_W +: REG_ADDR_W];
    assign w_src_hit[k] = io_sb.id_src_check[k] && (w_idx != '0) && (w_cnt[w_idx] != '0);
  end

  assign w_hazard = io_sb.id_valid && !io_sb.id_flush && (|w_src_hit);
  assign w_issue  = io_sb.id_valid && !io_sb.id_flush && !w_hazard && !io_sb.pipe_freeze;

  // Out-of-range latencies are clamped so a bad decode cannot wrap the counter.
  assign w_lat_ext     = 32'(io_sb.id_lat);
  assign w_lat_clamped = (w_lat_ext > MAX_LAT) ? CNT_W'(MAX_LAT) : io_sb.id_lat;
  assign w_load_val    = io_sb.forward_en ? w_lat_clamped : CNT_W'(WB_DIST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (w_hazard && (r_stall != {STALL_W{1'b1}})) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign io_sb.hazard_detected = w_hazard;
  assign io_sb.issue           = w_issue;
  assign io_sb.stall_cycles    = r_stall;

`ifndef SYNTHESIS
  a_lat_legal: assert property (@(posedge clk) disable iff (!rst_n)
    !(io_sb.id_valid && (w_lat_ext > MAX_LAT)));
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected outputs,
// a negedge monitor pops and compares against the DUT.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NREG = 2**REG_ADDR_W;

  typedef struct {
    logic        haz;
    logic        iss;
    logic [31:0] stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if sb ();

  hazard_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_sb (sb)
  );

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  longint ready_at [NREG];
  longint adv;
  longint m_stall;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp += 3;
      if (sb.hazard_detected !== e.haz) begin
        n_err++;
        $display("FAIL hazard_detected: got %b, expected %b (t=%0t)", sb.hazard_detected, e.haz, $time);
      end
      if (sb.issue !== e.iss) begin
        n_err++;
        $display("FAIL issue: got %b, expected %b (t=%0t)", sb.issue, e.iss, $time);
      end
      if (sb.stall_cycles !== e.stall) begin
        n_err++;
        $display("FAIL stall_cycles: got %0d, expected %0d (t=%0t)", sb.stall_cycles, e.stall, $time);
      end
    end
  end

  // Model: a register written at pipeline time A with latency L is readable once
  // L+1 further advancing (non-frozen) cycles have elapsed.
  task automatic model_reset();
    foreach (ready_at[i]) ready_at[i] = 0;
    adv     = 0;
    m_stall = 0;
  endtask

  task automatic step(input bit valid, input int s0, input int s1, input bit [1:0] chk,
                      input int dest, input bit wb, input int lat, input bit fwd,
                      input bit frz, input bit fl, output bit iss);
    bit   haz;
    int   srcs[2];
    exp_t e;
    sb.id_valid     = valid;
    sb.id_src       = {REG_ADDR_W'(s1), REG_ADDR_W'(s0)};
    sb.id_src_check = chk;
    sb.id_dest      = REG_ADDR_W'(dest);
    sb.id_wb_en     = wb;
    sb.id_lat       = CNT_W'(lat);
    sb.forward_en   = fwd;
    sb.pipe_freeze  = frz;
    sb.id_flush     = fl;
    srcs[0] = s0;
    srcs[1] = s1;
    haz = 1'b0;
    for (int k = 0; k < 2; k++)
      if (valid && !fl && chk[k] && srcs[k] != 0 && adv < ready_at[srcs[k]]) haz = 1'b1;
    iss = valid && !fl && !haz && !frz;
    e.haz   = haz;
    e.iss   = iss;
    e.stall = m_stall[31:0];
    exp_q.push_back(e);
    if (haz && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (!frz) begin
      if (iss && wb && dest != 0)
        ready_at[dest] = adv + 1 + (fwd ? ((lat > MAX_LAT) ? MAX_LAT : lat) : WB_DIST);
      adv++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit iss;
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, iss);
  endtask

  // Holds one instruction in ID until it issues; gives up after a fixed budget.
  task automatic issue_op(input string name, input int s0, input int s1, input bit [1:0] chk,
                          input int dest, input int lat, input bit fwd);
    bit iss;
    int n;
    n = 0;
    iss = 1'b0;
    while (!iss && n < 20) begin
      step(1, s0, s1, chk, dest, 1, lat, fwd, 0, 0, iss);
      n++;
    end
    if (!iss) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no issue after %0d cycles, expected issue", name, n);
    end
  endtask

  task automatic do_reset();
    exp_t e;
    rst_n = 1'b0;
    sb.id_valid    = 1'b0;
    sb.pipe_freeze = 1'b0;
    sb.id_flush    = 1'b0;
    model_reset();
    e.haz   = 1'b0;
    e.iss   = 1'b0;
    e.stall = '0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    longint base;
    bit     iss;
    bit     fwd;
    sb.forward_en   = 1'b1;
    sb.id_valid     = 1'b0;
    sb.id_src       = '0;
    sb.id_src_check = '0;
    sb.id_dest      = '0;
    sb.id_wb_en     = 1'b0;
    sb.id_lat       = '0;
    sb.pipe_freeze  = 1'b0;
    sb.id_flush     = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check("reset_stall_cycles", sb.stall_cycles, 0);

    // ALU result forwarded: dependent op never stalls.
    base = sb.stall_cycles;
    issue_op("alu_prod", 1, 2, 2'b11, 3, LAT_ALU, 1);
    issue_op("alu_dep", 3, 1, 2'b11, 4, LAT_ALU, 1);
    check("alu_fwd_stalls", sb.stall_cycles - base, 0);

    // Load-use: exactly one bubble.
    base = sb.stall_cycles;
    issue_op("lw_prod", 1, 0, 2'b01, 5, LAT_LOAD, 1);
    issue_op("lw_dep", 5, 2, 2'b11, 6, LAT_ALU, 1);
    check("load_use_stalls", sb.stall_cycles - base, 1);

    // No forwarding: wait for writeback, unless the operand is not read.
    idle(3);
    base = sb.stall_cycles;
    issue_op("nofwd_prod", 0, 0, 2'b00, 7, LAT_ALU, 0);
    issue_op("nofwd_dep", 2, 7, 2'b11, 8, LAT_ALU, 0);
    check("nofwd_stalls", sb.stall_cycles - base, WB_DIST);
    idle(3);
    base = sb.stall_cycles;
    issue_op("nofwd_prod2", 0, 0, 2'b00, 7, LAT_ALU, 0);
    issue_op("nofwd_unread", 2, 7, 2'b01, 8, LAT_ALU, 0);
    check("nofwd_unread_stalls", sb.stall_cycles - base, 0);

    // Multi-cycle op with a frozen pipeline: counters hold while frozen.
    idle(3);
    issue_op("mul_prod", 0, 0, 2'b00, 9, LAT_MUL, 1);
    base = sb.stall_cycles;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, iss);
    issue_op("mul_dep", 9, 0, 2'b01, 10, LAT_ALU, 1);
    check("mul_freeze_stalls", sb.stall_cycles - base, LAT_MUL);
    issue_op("mul_prod2", 0, 0, 2'b00, 9, LAT_MUL, 1);
    for (int i = 0; i < 2; i++) step(1, 9, 0, 2'b01, 11, 1, 0, 1, 1, 0, iss);
    issue_op("mul_dep2", 9, 0, 2'b01, 11, LAT_ALU, 1);

    // r0 never pending; flushed dependent is neither stalled nor issued.
    idle(5);
    base = sb.stall_cycles;
    issue_op("r0_write", 1, 0, 2'b01, 0, LAT_MUL, 0);
    issue_op("r0_read", 0, 0, 2'b11, 12, LAT_ALU, 0);
    check("r0_stalls", sb.stall_cycles - base, 0);
    idle(3);
    base = sb.stall_cycles;
    issue_op("lw_r4", 1, 0, 2'b01, 4, LAT_LOAD, 1);
    step(1, 4, 0, 2'b01, 13, 1, 0, 1, 0, 1, iss);
    issue_op("after_flush", 4, 0, 2'b01, 13, LAT_ALU, 1);
    check("flush_stalls", sb.stall_cycles - base, 0);

    // Reset in the middle of a pending write.
    issue_op("r5_pending", 0, 0, 2'b00, 5, 3, 1);
    do_reset();
    check("midreset_stall_cycles", sb.stall_cycles, 0);
    issue_op("post_reset", 5, 5, 2'b11, 1, LAT_ALU, 1);
    check("post_reset_stalls", sb.stall_cycles, 0);

    // Randomized traffic against the model.
    fwd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) fwd = ~fwd;
      step($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
           2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, MAX_LAT), fwd, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 10, iss);
      if (i == 1500) do_reset();
    end
    idle(2);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
